// File: rtl/dense_layer_mac_array.sv
// Fully-connected layer engine: LANES signed MACs sweep OUTNODE/LANES neuron groups over a streamed weight port.
// Define DENSE_RELU_EN to clamp negative saturated results to zero (fused ReLU); latency is unchanged.
module dense_layer_mac_array #(
  parameter int WIDTH   = 8,
  parameter int INNODE  = 10,
  parameter int OUTNODE = 10,
  parameter int LANES   = 2,
  parameter int ACCW    = 20,
  parameter int FRAC    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH*INNODE-1:0]    in,
  input  logic [WIDTH*OUTNODE-1:0]   bias,
  input  logic [WIDTH*LANES-1:0]     w_data,
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic [WIDTH*OUTNODE-1:0]   out,
  output logic                       valid,
  output logic                       busy,
  output logic                       getinput
);

  localparam int GROUPS = OUTNODE / LANES;
  localparam int IW     = (INNODE > 1) ? $clog2(INNODE) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(INNODE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH*INNODE-1:0]   in_q;
  logic [WIDTH*OUTNODE-1:0]  bias_q;
  logic [IW-1:0]             idx;
  logic [GW-1:0]             grp;
  logic signed [ACCW-1:0]    acc  [LANES];
  logic signed [ACCW-1:0]    prod [LANES];
  logic signed [2*WIDTH-1:0] pfull [LANES];
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [WIDTH-1:0]   w_lane [LANES];

  function automatic logic signed [ACCW-1:0] bias_ext(input logic signed [WIDTH-1:0] b);
    logic signed [ACCW-1:0] e;
    e = ACCW'(b);
    return e <<< FRAC;
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    r = a >>> FRAC;
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
`ifdef DENSE_RELU_EN
    if (r[ACCW-1]) r = '0;
`else
`endif
    return WIDTH'(r);
  endfunction

  // Full-width signed product per lane, then sign-extended into the accumulator width.
  always_comb begin
    x_sel = in_q[int'(idx)*WIDTH +: WIDTH];
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane[l] = w_data[l*WIDTH +: WIDTH];
      pfull[l]  = w_lane[l] * x_sel;
      prod[l]   = ACCW'(pfull[l]);
    end
  end

  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC: begin
        w_ready = 1'b1;
        if (w_valid && idx == I_LAST) state_d = WRITE;
      end
      WRITE:   state_d = (grp == G_LAST) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q     <= '0;
      bias_q   <= '0;
      idx      <= '0;
      grp      <= '0;
      out      <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      getinput <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      valid    <= 1'b0;
      getinput <= 1'b0;
      busy     <= (state_d != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            in_q     <= in;
            bias_q   <= bias;
            idx      <= '0;
            grp      <= '0;
            getinput <= 1'b1;
            for (int unsigned l = 0; l < LANES; l++)
              acc[l] <= bias_ext(bias[l*WIDTH +: WIDTH]);
          end
        end
        MAC: begin
          if (w_valid) begin
            for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc[l] + prod[l];
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
          end
        end
        WRITE: begin
          for (int unsigned l = 0; l < LANES; l++)
            out[(int'(grp)*LANES + l)*WIDTH +: WIDTH] <= saturate(acc[l]);
          if (grp == G_LAST) begin
            valid <= 1'b1;
          end else begin
            grp <= grp + 1'b1;
            idx <= '0;
            // Reload from the captured bias, since the source may have changed it after getinput.
            for (int unsigned l = 0; l < LANES; l++)
              acc[l] <= bias_ext(bias_q[((int'(grp) + 1)*LANES + l)*WIDTH +: WIDTH]);
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac_array.sv
// Scoreboard bench for dense_layer_mac_array: a driver streams weights and queues expected results, a monitor checks each valid pulse.
module tb_dense_layer_mac_array;
  localparam int W = 8, NI = 4, NO = 4, LN = 2, NG = NO / LN, AW = 20;
  localparam int TOTAL = NG * NI;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, w_valid = 1'b0;
  logic [W*NI-1:0] in_bus = '0;
  logic [W*NO-1:0] bias_bus = '0;
  logic [W*LN-1:0] w_data = '0;
  logic            w_ready, valid, busy, getinput;
  logic [W*NO-1:0] out;

  logic            fx_start = 1'b0;
  logic [W*NI-1:0] fx_in = '0;
  logic [W*NO-1:0] fx_bias = '0;
  logic [W*LN-1:0] fx_w_data = '0;
  logic            fx_w_ready, fx_valid, fx_busy, fx_getinput;
  logic [W*NO-1:0] fx_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0, mismatched = 0;
  int x [NI];
  int b [NO];
  int wt [NO][NI];

  typedef struct {
    logic [W*NO-1:0] vec;
    int              cyc;
  } exp_t;
  exp_t exp_q[$];

  dense_layer_mac_array #(.WIDTH(W), .INNODE(NI), .OUTNODE(NO), .LANES(LN), .ACCW(AW), .FRAC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in_bus), .bias(bias_bus),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .out(out),
    .valid(valid), .busy(busy), .getinput(getinput)
  );

  dense_layer_mac_array #(.WIDTH(W), .INNODE(NI), .OUTNODE(NO), .LANES(LN), .ACCW(24), .FRAC(4)) dut_fx (
    .clk(clk), .reset(reset), .start(fx_start), .in(fx_in), .bias(fx_bias),
    .w_data(fx_w_data), .w_valid(1'b1), .w_ready(fx_w_ready), .out(fx_out),
    .valid(fx_valid), .busy(fx_busy), .getinput(fx_getinput)
  );

  task automatic chk(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Reference: out[n] = sat((bias<<frac + sum w*x) >> frac), computed on plain integers.
  function automatic logic [W*NO-1:0] model(input int frac);
    logic [W*NO-1:0] v;
    longint s, hi, lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -hi - 1;
    v = '0;
    for (int n = 0; n < NO; n++) begin
      s = longint'(b[n]) * (longint'(1) << frac);
      for (int i = 0; i < NI; i++) s += longint'(wt[n][i]) * longint'(x[i]);
      s = s >>> frac;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`ifdef DENSE_RELU_EN
      if (s < 0) s = 0;
`else
`endif
      v[n*W +: W] = W'(s);
    end
    return v;
  endfunction

  function automatic logic [W*NI-1:0] pack_in();
    logic [W*NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(x[i]);
    return v;
  endfunction

  function automatic logic [W*NO-1:0] pack_bias();
    logic [W*NO-1:0] v;
    for (int n = 0; n < NO; n++) v[n*W +: W] = W'(b[n]);
    return v;
  endfunction

  function automatic logic [W*LN-1:0] beat(input int k);
    logic [W*LN-1:0] v;
    for (int l = 0; l < LN; l++) v[l*W +: W] = W'(wt[(k / NI)*LN + l][k % NI]);
    return v;
  endfunction

  task automatic fill(input int xv, input int wv, input int bv);
    for (int i = 0; i < NI; i++) x[i] = xv;
    for (int n = 0; n < NO; n++) begin
      b[n] = bv;
      for (int i = 0; i < NI; i++) wt[n][i] = wv;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NI; i++) x[i] = int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < NO; n++) begin
      b[n] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NI; i++) wt[n][i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out", out, e.vec);
          chk("valid_cycle", cyc, e.cyc);
          chk("w_ready_in_done", w_ready, 0);
        end
      end
    end
  end

  task automatic run(input bit push, input int stall_at, input int stall_n, input bit poke, input int abort_at);
    logic [W*NO-1:0] ev;
    exp_t en;
    int s0, k, stalls, guard, left;
    bit acc_now, poked;
    ev = model(0);
    @(negedge clk);
    in_bus = pack_in();
    bias_bus = pack_bias();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s0 = cyc - 1;
    chk("getinput_cycle1", getinput, 1);
    chk("busy_cycle1", busy, 1);
    chk("w_ready_cycle1", w_ready, 1);
    k = 0; stalls = 0; guard = 0; left = stall_n; poked = 1'b0;
    while (k < TOTAL) begin
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        w_valid = 1'b0;
        #1;
        chk("async_reset_out", out, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_w_ready", w_ready, 0);
        chk("reset_out", out, 0);
        repeat (30) @(negedge clk);
        return;
      end
      start = poke && !poked && k == 2;
      if (start) poked = 1'b1;
      w_data = beat(k);
      if (k == stall_at && left > 0 && w_ready) begin
        w_valid = 1'b0;
        left--;
        stalls++;
      end else w_valid = 1'b1;
      acc_now = w_valid && w_ready;
      if (acc_now) chk("beat_cycle", cyc - s0, 1 + k + k / NI + stalls);
      @(negedge clk);
      if (acc_now) k++;
      guard++;
      if (guard > 200) begin
        chk("feed_timeout", 1, 0);
        break;
      end
    end
    w_valid = 1'b0;
    start = 1'b0;
    if (push) begin
      en.vec = ev;
      en.cyc = s0 + NG*(NI + 1) + 1 + stalls;
      exp_q.push_back(en);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("valid_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [W*NO-1:0] fev;
    bit seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_getinput", getinput, 0);

    fill(1, 1, 0);        run(1, -1, 0, 0, -1);
    fill(127, 127, 127);  run(1, -1, 0, 0, -1);
    fill(127, -128, 127); run(1, -1, 0, 0, -1);
    fill(1, 1, 0);        run(1, NI + 1, 3, 0, -1);
    fill(1, 1, 0);        run(1, -1, 0, 1, -1);
    fill(3, -2, 5);       run(0, -1, 0, 0, 3);
    fill(1, 1, 0);        run(1, -1, 0, 0, -1);

    fill(1, 0, 0);
    for (int n = 0; n < NO; n++)
      for (int i = 0; i < NI; i++) wt[n][i] = n + 1;
    run(1, -1, 0, 0, -1);

    for (int r = 0; r < 12; r++) begin
      fill_random();
      run(1, int'($urandom_range(0, TOTAL - 1)), int'($urandom_range(0, 3)), 1'b0, -1);
    end

    fill(16, 8, 16);
    fev = model(4);
    @(negedge clk);
    fx_in = pack_in();
    fx_bias = pack_bias();
    fx_w_data = beat(0);
    fx_start = 1'b1;
    @(negedge clk);
    fx_start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (fx_valid) begin
        seen = 1'b1;
        chk("fx_out", fx_out, fev);
      end
    end
    if (!seen) chk("fx_valid_timeout", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
